// File: rtl/mouse_pkg.sv
// Shared constants and types for the PS/2 mouse cursor position controller.
package mouse_pkg;

  // Default display geometry
  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;

  // Width of the signed position arithmetic
  localparam int unsigned CALC_W = 12;

  // PS/2 byte0 bit positions
  localparam int unsigned B0_LEFT   = 0;
  localparam int unsigned B0_RIGHT  = 1;
  localparam int unsigned B0_MIDDLE = 2;
  localparam int unsigned B0_SYNC   = 3;
  localparam int unsigned B0_XSIGN  = 4;
  localparam int unsigned B0_YSIGN  = 5;
  localparam int unsigned B0_XOVF   = 6;
  localparam int unsigned B0_YOVF   = 7;

  typedef enum logic [1:0] {
    WAIT_B0,
    WAIT_B1,
    WAIT_B2,
    ACCUM
  } mouse_state_t;

endpackage

// File: rtl/mouse_clamp_add.sv
// Combinational signed add of a position and a delta, clamped to [0, LIMIT-1].
module mouse_clamp_add #(
  parameter int unsigned LIMIT = 640
) (
  input  logic signed [11:0] base,
  input  logic signed [11:0] delta,
  output logic        [11:0] result
);

  logic [12:0] sum;

  // One extra bit keeps the sum from wrapping before it is clamped
  always_comb begin
    sum    = {base[11], base} + {delta[11], delta};
    result = sum[11:0];
    if (sum[12]) begin
      result = '0;
    end else if (sum[11:0] > 12'(LIMIT - 1)) begin
      result = 12'(LIMIT - 1);
    end
  end

endmodule

// File: rtl/mouse_pos_ctrl.sv
// PS/2 mouse packet decoder that accumulates a clamped cursor position and
// publishes it to the VGA cursor renderer once per frame.
module mouse_pos_ctrl #(
  parameter int unsigned H_RES   = mouse_pkg::H_RES,
  parameter int unsigned V_RES   = mouse_pkg::V_RES,
  parameter int unsigned INIT_X  = 320,
  parameter int unsigned INIT_Y  = 240,
  parameter int unsigned TIMEOUT = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  input  logic        frame_start,
  output logic [15:0] mouse_position_x,
  output logic [15:0] mouse_position_y,
  output logic [2:0]  buttons,
  output logic        pkt_err
);

  import mouse_pkg::*;

  mouse_state_t state, state_next;
  logic         accept;
  logic         timeout;
  logic         err_next;
  logic [31:0]  gap_cnt;
  logic [7:0]   byte0, byte1, byte2;
  logic [11:0]  pend_x, pend_y;
  logic [2:0]   pend_btn;
  logic [11:0]  dx_ext, dy_ext, dy_neg;
  logic [11:0]  next_x, next_y;

  assign byte_ready = (state != ACCUM);
  assign accept     = byte_valid && byte_ready;
  assign timeout    = (gap_cnt == 32'(TIMEOUT));

  // Sign-extended deltas; overflow forces the axis delta to zero, and Y is
  // negated because PS/2 +Y points up while screen lines count downward
  assign dx_ext = byte0[B0_XOVF] ? '0 : {{4{byte0[B0_XSIGN]}}, byte1};
  assign dy_ext = byte0[B0_YOVF] ? '0 : {{4{byte0[B0_YSIGN]}}, byte2};
  assign dy_neg = -dy_ext;

  mouse_clamp_add #(.LIMIT(H_RES)) u_clamp_x (
    .base   (pend_x),
    .delta  (dx_ext),
    .result (next_x)
  );

  mouse_clamp_add #(.LIMIT(V_RES)) u_clamp_y (
    .base   (pend_y),
    .delta  (dy_neg),
    .result (next_y)
  );

  // State register and registered error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_B0;
      pkt_err <= 1'b0;
    end else begin
      state   <= state_next;
      pkt_err <= err_next;
    end
  end

  // Next-state logic; an accepted byte always wins over a coincident timeout
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      WAIT_B0: begin
        if (accept) begin
          if (byte_data[B0_SYNC]) state_next = WAIT_B1;
          else                    err_next   = 1'b1;
        end
      end
      WAIT_B1: begin
        if (accept) begin
          state_next = WAIT_B2;
        end else if (timeout) begin
          state_next = WAIT_B0;
          err_next   = 1'b1;
        end
      end
      WAIT_B2: begin
        if (accept) begin
          state_next = ACCUM;
        end else if (timeout) begin
          state_next = WAIT_B0;
          err_next   = 1'b1;
        end
      end
      ACCUM:   state_next = WAIT_B0;
      default: state_next = WAIT_B0;
    endcase
  end

  // Inter-byte gap counter, live only while a packet is partially received
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if ((state == WAIT_B1) || (state == WAIT_B2)) begin
      if (accept || timeout) gap_cnt <= '0;
      else                   gap_cnt <= gap_cnt + 32'd1;
    end else begin
      gap_cnt <= '0;
    end
  end

  // Capture the three packet bytes as they are accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte0 <= '0;
      byte1 <= '0;
      byte2 <= '0;
    end else if (accept) begin
      if ((state == WAIT_B0) && byte_data[B0_SYNC]) byte0 <= byte_data;
      if (state == WAIT_B1)                         byte1 <= byte_data;
      if (state == WAIT_B2)                         byte2 <= byte_data;
    end
  end

  // Pending position and buttons, updated once per complete packet
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_x   <= 12'(INIT_X);
      pend_y   <= 12'(INIT_Y);
      pend_btn <= '0;
    end else if (state == ACCUM) begin
      pend_x   <= next_x;
      pend_y   <= next_y;
      pend_btn <= {byte0[B0_MIDDLE], byte0[B0_RIGHT], byte0[B0_LEFT]};
    end
  end

  // Outputs only move at frame start, taking the pre-ACCUM pending values
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mouse_position_x <= 16'(INIT_X);
      mouse_position_y <= 16'(INIT_Y);
      buttons          <= '0;
    end else if (frame_start) begin
      mouse_position_x <= {4'b0000, pend_x};
      mouse_position_y <= {4'b0000, pend_y};
      buttons          <= pend_btn;
    end
  end

endmodule

// File: tb/tb_mouse_pos_ctrl.sv
// Self-checking bench for mouse_pos_ctrl: directed scenarios plus random
// packets compared against a packet-level reference model.
module tb_mouse_pos_ctrl;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        frame_start;
  logic [15:0] mouse_position_x;
  logic [15:0] mouse_position_y;
  logic [2:0]  buttons;
  logic        pkt_err;

  int checks = 0;
  int errors = 0;
  int err_pulses = 0;
  int m_err = 0;
  int m_px, m_py, m_pb, m_ox, m_oy, m_ob;

  always #5 clk = ~clk;

  mouse_pos_ctrl #(
    .H_RES   (640),
    .V_RES   (480),
    .INIT_X  (320),
    .INIT_Y  (240),
    .TIMEOUT (TMO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .frame_start      (frame_start),
    .mouse_position_x (mouse_position_x),
    .mouse_position_y (mouse_position_y),
    .buttons          (buttons),
    .pkt_err          (pkt_err)
  );

  // Count every cycle pkt_err is high, sampled away from the active edge
  always @(negedge clk) if (pkt_err === 1'b1) err_pulses++;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic void model_reset();
    m_px = 320; m_py = 240; m_pb = 0;
    m_ox = 320; m_oy = 240; m_ob = 0;
  endfunction

  function automatic void model_pkt(input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2);
    int dx, dy;
    dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
    dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
    m_px = clampi(m_px + dx, 639);
    m_py = clampi(m_py - dy, 479);
    m_pb = int'(b0[2:0]);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    check_val("ready_before_byte", int'(byte_ready), 1);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_ox = m_px; m_oy = m_py; m_ob = m_pb;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int gap, input bit fs_in_accum, input bit junk_in_accum);
    send_byte(b0);
    idle(gap);
    send_byte(b1);
    idle(gap);
    send_byte(b2);
    check_val("ready_in_accum", int'(byte_ready), 0);
    if (junk_in_accum) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
    end
    if (fs_in_accum) frame_start = 1'b1;
    tick();
    byte_valid  = 1'b0;
    frame_start = 1'b0;
    if (fs_in_accum) begin
      m_ox = m_px; m_oy = m_py; m_ob = m_pb;
    end
    model_pkt(b0, b1, b2);
  endtask

  task automatic check_out(input string tag);
    check_val({tag, "_x"},   int'(mouse_position_x), m_ox);
    check_val({tag, "_y"},   int'(mouse_position_y), m_oy);
    check_val({tag, "_btn"}, int'(buttons),          m_ob);
    check_val({tag, "_err"}, err_pulses,             m_err);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check_val("rst_async_x",   int'(mouse_position_x), 320);
    check_val("rst_async_y",   int'(mouse_position_y), 240);
    check_val("rst_async_btn", int'(buttons),          0);
    check_val("rst_ready",     int'(byte_ready),       1);
    check_val("rst_pkt_err",   int'(pkt_err),          0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    tick();
  endtask

  initial begin
    int     seen;
    int     wait_n;
    logic [7:0] r0, r1, r2;

    rst = 1'b1; byte_valid = 1'b0; byte_data = '0; frame_start = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_val("reset_x",     int'(mouse_position_x), 320);
    check_val("reset_y",     int'(mouse_position_y), 240);
    check_val("reset_btn",   int'(buttons),          0);
    check_val("reset_ready", int'(byte_ready),       1);
    check_val("reset_err",   int'(pkt_err),          0);
    tick();

    // Basic packet: dx=+10, dy=+5 (up)
    send_pkt(8'h08, 8'h0A, 8'h05, 0, 1'b0, 1'b0);
    frame_pulse();
    check_val("basic_x",   int'(mouse_position_x), 330);
    check_val("basic_y",   int'(mouse_position_y), 235);
    check_val("basic_btn", int'(buttons),          0);

    // Clamp at both edges
    pulse_reset();
    send_pkt(8'h18, 8'h01, 8'h00, 1, 1'b0, 1'b0);
    send_pkt(8'h18, 8'hC4, 8'h00, 0, 1'b0, 1'b0);
    frame_pulse();
    check_val("pre_clamp_x", int'(mouse_position_x), 5);
    send_pkt(8'h18, 8'hF6, 8'h00, 0, 1'b0, 1'b0);
    frame_pulse();
    check_val("clamp_lo_x", int'(mouse_position_x), 0);
    send_pkt(8'h28, 8'h00, 8'h15, 2, 1'b0, 1'b0);
    frame_pulse();
    check_val("pre_clamp_y", int'(mouse_position_y), 475);
    send_pkt(8'h28, 8'h00, 8'hF0, 0, 1'b0, 1'b0);
    frame_pulse();
    check_val("clamp_hi_y", int'(mouse_position_y), 479);
    check_val("clamp_hi_x", int'(mouse_position_x), 0);
    check_out("clamp");

    // Framing error on byte0, then a clean packet
    send_byte(8'h02);
    check_val("frame_err_pulse", int'(pkt_err), 1);
    tick();
    check_val("frame_err_clear", int'(pkt_err), 0);
    m_err++;
    send_pkt(8'h0F, 8'h10, 8'h20, 0, 1'b0, 1'b0);
    frame_pulse();
    check_out("after_frame_err");

    // Timeout mid-packet
    send_byte(8'h09);
    send_byte(8'h03);
    seen = 0;
    wait_n = 0;
    for (int i = 1; i <= int'(TMO) + 10; i++) begin
      tick();
      if (pkt_err === 1'b1) begin
        seen = 1;
        wait_n = i;
        break;
      end
    end
    check_val("timeout_seen", seen, 1);
    check_val("timeout_window", int'((wait_n >= int'(TMO)) && (wait_n <= int'(TMO) + 2)), 1);
    tick();
    check_val("timeout_clear", int'(pkt_err), 0);
    m_err++;
    frame_pulse();
    check_out("after_timeout");
    send_pkt(8'h08, 8'h04, 8'h00, 0, 1'b0, 1'b0);
    frame_pulse();
    check_out("resync_after_timeout");

    // A byte arriving exactly at the timeout boundary is still accepted
    send_pkt(8'h09, 8'h02, 8'h03, int'(TMO), 1'b0, 1'b0);
    frame_pulse();
    check_out("boundary_gap");

    // frame_start coinciding with ACCUM shows the old pending values
    send_pkt(8'h0A, 8'h20, 8'h00, 0, 1'b1, 1'b0);
    check_out("fs_in_accum_old");
    frame_pulse();
    check_out("fs_in_accum_new");

    // X overflow suppresses the X delta
    send_pkt(8'h48, 8'h7F, 8'h00, 0, 1'b0, 1'b0);
    frame_pulse();
    check_out("x_overflow");

    // Reset mid-packet discards the partial packet
    send_byte(8'h08);
    send_byte(8'h30);
    pulse_reset();
    frame_pulse();
    check_val("midrst_x",   int'(mouse_position_x), 320);
    check_val("midrst_y",   int'(mouse_position_y), 240);
    check_val("midrst_btn", int'(buttons),          0);
    send_pkt(8'h08, 8'h01, 8'h01, 0, 1'b0, 1'b0);
    frame_pulse();
    check_out("after_midrst");

    // Randomized packets
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        r0 = 8'($urandom) & 8'hF7;
        send_byte(r0);
        check_val("rand_frame_err", int'(pkt_err), 1);
        m_err++;
        tick();
      end else begin
        r0 = 8'($urandom) | 8'h08;
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        send_pkt(r0, r1, r2, int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 1) == 1) frame_pulse();
      end
      check_out("rand");
    end
    frame_pulse();
    check_out("rand_final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
